// File: rtl/corevx_bus_pkg.sv
// Shared bus encodings for the core's memory-transaction initiators and targets.
package corevx_bus_pkg;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;

  localparam logic [2:0] RESPONSE_SUCCESS     = 3'd0;
  localparam logic [2:0] RESPONSE_ACCESSFAULT = 3'd1;
  localparam logic [2:0] RESPONSE_UNKNOWNCMD  = 3'd2;
  localparam logic [2:0] RESPONSE_MISSALIGNED = 3'd3;

endpackage

// File: rtl/corevx_mem_responder_ram.sv
// Word RAM: one synchronous read port, a byte-strobed bus write port and a
// lower-priority full-word backdoor write port.
module corevx_mem_responder_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_be,
  input  logic                  bd_en,
  input  logic [DEPTH_LOG2-1:0] bd_idx,
  input  logic [31:0]           bd_data
);

  logic [31:0] mem [1 << DEPTH_LOG2];

  // Bus bytes are written after the backdoor word so they override it on a collision.
  always_ff @(posedge clk) begin
    if (bd_en) mem[bd_idx] <= bd_data;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Output reads as zero on any cycle without a read, so no reset is needed here.
  always_ff @(posedge clk) begin
    rd_data <= rd_en ? mem[rd_idx] : 32'h0;
  end

endmodule

// File: rtl/corevx_mem_responder.sv
// Single-outstanding bus target answering memory transactions from an internal
// RAM after a fixed latency, with a backdoor preload port.
//
// state | meaning
// IDLE  | waiting for m_transaction; captures the request when it is high
// WAIT  | latency countdown on the captured request
// DONE  | one-cycle completion; response and read data are valid
module corevx_mem_responder
  import corevx_bus_pkg::*;
#(
  parameter logic [33:0] BASE_ADDR  = 34'h0,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_transaction,
  input  logic [2:0]            m_cmd,
  input  logic [33:0]           m_address,
  input  logic [31:0]           m_wdata,
  input  logic [3:0]            m_wbyte_enable,
  output logic                  m_transaction_done,
  output logic [2:0]            m_transaction_response,
  output logic [31:0]           m_rdata,
  input  logic                  bd_write,
  input  logic [DEPTH_LOG2-1:0] bd_word_index,
  input  logic [31:0]           bd_wdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        capture;

  logic [2:0]  cmd_q;
  logic [33:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [2:0]  cmd_eff;
  logic [33:0] addr_eff;
  logic [31:0] wdata_eff;
  logic [3:0]  be_eff;
  logic [33:0] offset;
  logic        in_range;
  logic [2:0]  resp_eff;
  logic        enter_done;
  logic        ram_rd_en;
  logic        ram_wr_en;

  // With LATENCY=1 the accept edge is also the commit edge, so decode must
  // look through to the live inputs while still in IDLE.
  always_comb begin
    cmd_eff   = cmd_q;
    addr_eff  = addr_q;
    wdata_eff = wdata_q;
    be_eff    = be_q;
    if (state == ST_IDLE) begin
      cmd_eff   = m_cmd;
      addr_eff  = m_address;
      wdata_eff = m_wdata;
      be_eff    = m_wbyte_enable;
    end
  end

  assign offset   = addr_eff - BASE_ADDR;
  assign in_range = (addr_eff >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == '0);

  always_comb begin
    resp_eff = RESPONSE_SUCCESS;
    if (cmd_eff != CMD_READ && cmd_eff != CMD_WRITE) resp_eff = RESPONSE_UNKNOWNCMD;
    else if (addr_eff[1:0] != 2'b00)                 resp_eff = RESPONSE_MISSALIGNED;
    else if (!in_range)                              resp_eff = RESPONSE_ACCESSFAULT;
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m_transaction) begin
          capture    = 1'b1;
          cnt_next   = LAT_M1;
          state_next = (LATENCY == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign enter_done = rst_n && (state_next == ST_DONE);
  assign ram_rd_en  = enter_done && (resp_eff == RESPONSE_SUCCESS) && (cmd_eff == CMD_READ);
  assign ram_wr_en  = enter_done && (resp_eff == RESPONSE_SUCCESS) && (cmd_eff == CMD_WRITE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                  <= ST_IDLE;
      cnt                    <= 4'd0;
      m_transaction_done     <= 1'b0;
      m_transaction_response <= RESPONSE_SUCCESS;
    end else begin
      state                  <= state_next;
      cnt                    <= cnt_next;
      m_transaction_done     <= enter_done;
      m_transaction_response <= enter_done ? resp_eff : RESPONSE_SUCCESS;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      cmd_q   <= m_cmd;
      addr_q  <= m_address;
      wdata_q <= m_wdata;
      be_q    <= m_wbyte_enable;
    end
  end

  corevx_mem_responder_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rd_en   (ram_rd_en),
    .rd_idx  (offset[DEPTH_LOG2+1:2]),
    .rd_data (m_rdata),
    .wr_en   (ram_wr_en),
    .wr_idx  (offset[DEPTH_LOG2+1:2]),
    .wr_data (wdata_eff),
    .wr_be   (be_eff),
    .bd_en   (bd_write),
    .bd_idx  (bd_word_index),
    .bd_data (bd_wdata)
  );

endmodule
